// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad matrix scanner.
//  - kp_state_e : debounce FSM state encoding
//  - KEY_NONE   : value of the frame-result "none" flag when no key was seen
//  - KP_*       : default matrix geometry and timing
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CONFIRM   = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_RELEASING = 2'd3
  } kp_state_e;

  localparam logic KEY_NONE = 1'b1;

  localparam int KP_ROWS     = 4;
  localparam int KP_COLS     = 4;
  localparam int KP_SCAN_DIV = 4;
  localparam int KP_DEBOUNCE = 3;

endpackage

// File: rtl/keypad_col_sync.sv
// col_sync: W-wide two-flop synchroniser for the asynchronous, active-low
// column returns. Resets to all 1 (no key seen).
//  clk   in  1  system clock
//  rst_n in  1  asynchronous active-low reset
//  d_n   in  W  raw column inputs
//  q_n   out W  synchronised column inputs
module col_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_n,
  output logic [W-1:0] q_n
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_n;
      sync_q <= meta_q;
    end
  end

  assign q_n = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: row-scanning matrix keypad reader with frame-level debounce.
//  clk       in  1     system clock
//  rst_n     in  1     asynchronous active-low reset
//  row_n     out ROWS  one-hot-low row drive
//  col_n     in  COLS  active-low column returns (asynchronous)
//  key_code  out CW    last accepted key index (row*COLS+col)
//  key_valid out 1     one-cycle pulse on each accepted press
//  key_held  out 1     high from accept until debounced release
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = KP_ROWS,
  parameter int COLS     = KP_COLS,
  parameter int SCAN_DIV = KP_SCAN_DIV,
  parameter int DEBOUNCE = KP_DEBOUNCE,
  parameter int CW       = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row_n,
  input  logic [COLS-1:0] col_n,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int NW = $clog2(DEBOUNCE+1);

  logic [COLS-1:0] col_s;
  logic [SW-1:0]   slot_q, slot_d;
  logic [RW-1:0]   row_q, row_d;
  logic            hit_q, hit_d;
  logic [CW-1:0]   acc_q, acc_d;
  kp_state_e       state_q, state_d;
  logic [CW-1:0]   cand_q, cand_d;
  logic [NW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]   code_q, code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;

  logic            slot_last, frame_end, col_hit, is_none, at_deb;
  int              col_idx;
  logic [CW-1:0]   cur_key, frame_key;

  col_sync #(.W(COLS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_n   (col_n),
    .q_n   (col_s)
  );

  assign slot_last = (slot_q == SW'(SCAN_DIV-1));
  assign frame_end = slot_last && (row_q == RW'(ROWS-1));

  // Lowest pressed column of the row currently driven.
  always_comb begin
    col_hit = 1'b0;
    col_idx = 0;
    for (int c = COLS-1; c >= 0; c--) begin
      if (!col_s[c]) begin
        col_hit = 1'b1;
        col_idx = c;
      end
    end
  end

  assign cur_key = CW'(int'(row_q) * COLS + col_idx);

  // Rows are scanned in ascending order, so the first hit of a frame is the
  // lowest index; the final slot's own sample is folded in at frame end.
  assign is_none   = ((hit_q || (slot_last && col_hit)) ? ~KEY_NONE : KEY_NONE) == KEY_NONE;
  assign frame_key = hit_q ? acc_q : cur_key;

  assign cnt_inc = (cnt_q >= NW'(DEBOUNCE)) ? cnt_q : cnt_q + NW'(1);
  assign at_deb  = (cnt_inc == NW'(DEBOUNCE));

  always_comb begin
    slot_d = slot_last ? '0 : slot_q + SW'(1);
    row_d  = row_q;
    if (slot_last) row_d = (row_q == RW'(ROWS-1)) ? '0 : row_q + RW'(1);

    hit_d = hit_q;
    acc_d = acc_q;
    if (slot_last && col_hit && !hit_q) begin
      hit_d = 1'b1;
      acc_d = cur_key;
    end
    if (frame_end) hit_d = 1'b0;

    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (!is_none) begin
            cand_d = frame_key;
            cnt_d  = NW'(1);
            if (DEBOUNCE == 1) begin
              state_d = ST_PRESSED;
              code_d  = frame_key;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              state_d = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (is_none) begin
            state_d = ST_IDLE;
          end else if (frame_key == cand_q) begin
            cnt_d = cnt_inc;
            if (at_deb) begin
              state_d = ST_PRESSED;
              code_d  = frame_key;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end
          end else begin
            cand_d = frame_key;
            cnt_d  = NW'(1);
          end
        end
        ST_PRESSED: begin
          // No rollover: a second key while held is ignored.
          if (is_none) begin
            cnt_d = NW'(1);
            if (DEBOUNCE == 1) begin
              state_d = ST_IDLE;
              held_d  = 1'b0;
            end else begin
              state_d = ST_RELEASING;
            end
          end
        end
        ST_RELEASING: begin
          if (is_none) begin
            cnt_d = cnt_inc;
            if (at_deb) begin
              state_d = ST_IDLE;
              held_d  = 1'b0;
            end
          end else if (frame_key == code_q) begin
            state_d = ST_PRESSED;  // release bounce, same key back
          end else begin
            state_d = ST_CONFIRM;
            cand_d  = frame_key;
            cnt_d   = NW'(1);
            held_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      row_q   <= '0;
      hit_q   <= 1'b0;
      acc_q   <= '0;
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      row_q   <= row_d;
      hit_q   <= hit_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign row_n     = ~(ROWS'(1) << row_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad matrix model driven by a key set, with a frame-level
// reference model (run length of identical frame results) checked every cycle.
module tb_keypad_scan;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SD    = 4;
  localparam int DEB   = 3;
  localparam int FRAME = ROWS * SD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic [3:0]      key_code;
  logic            key_valid, key_held;
  logic [ROWS*COLS-1:0] keys = '0;

  always #5 clk = ~clk;

  keypad_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Passive matrix: a pressed key shorts its driven-low row to its column.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_n[r] && keys[r*COLS+c]) col_n[c] = 1'b0;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int cyc = 0, fr_key = -1, prev_res = -1, run = 0, m_code = 0, n_pulse = 0;
  bit m_held = 1'b0, m_valid = 1'b0;
  int t_r, t_slot, t_f, t_res, t_old;
  logic [ROWS-1:0] exp_row;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; fr_key = -1; prev_res = -1; run = 0;
      m_code = 0; m_held = 1'b0; m_valid = 1'b0;
    end else begin
      t_slot = cyc % SD;
      t_r    = (cyc / SD) % ROWS;
      t_f    = cyc % FRAME;
      exp_row = '1;
      exp_row[t_r] = 1'b0;
      chk("row_n", 32'(row_n), 32'(exp_row));
      chk("key_valid", 32'(key_valid), 32'(m_valid));
      chk("key_held", 32'(key_held), 32'(m_held));
      chk("key_code", 32'(key_code), 32'(m_code));
      if (key_valid) n_pulse++;
      m_valid = 1'b0;
      // Row r is judged from the column state two clocks before its slot ends.
      if (t_slot == SD-3)
        for (int c = 0; c < COLS; c++)
          if (fr_key < 0 && keys[t_r*COLS+c]) fr_key = t_r*COLS + c;
      if (t_f == FRAME-1) begin
        t_res  = fr_key;
        fr_key = -1;
        t_old  = prev_res;
        run    = (t_res == t_old) ? ((run < 1000) ? run + 1 : run) : 1;
        if (m_held) begin
          if (t_res < 0) begin
            if (run >= DEB) m_held = 1'b0;
          end else if (t_old < 0 && t_res != m_code) begin
            m_held = 1'b0;
          end
        end else if (t_res >= 0 && run >= DEB) begin
          m_held  = 1'b1;
          m_code  = t_res;
          m_valid = 1'b1;
        end
        prev_res = t_res;
      end
      cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align_frame();
    int i;
    i = 0;
    @(posedge clk);
    while (cyc % FRAME != 0 && i < 2*FRAME) begin
      @(posedge clk);
      i++;
    end
    chk("frame_align", 32'(cyc % FRAME), 32'd0);
    #1;
  endtask

  task automatic wait_pulse(input int base, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      if (n_pulse > base) break;
    end
    chk("pulse_latency", 32'(n_pulse > base), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_row"},   32'(row_n),     32'(4'b1110));
    chk({tag, "_valid"}, 32'(key_valid), 32'd0);
    chk({tag, "_held"},  32'(key_held),  32'd0);
    chk({tag, "_code"},  32'(key_code),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base;
  int k;

  initial begin
    // 1: reset and idle scanning
    repeat (3) @(posedge clk);
    #1 chk_reset_outs("rst");
    #1 rst_n = 1'b1;
    base = n_pulse;
    step(200);
    chk("t1_pulses", 32'(n_pulse - base), 32'd0);

    // 2: single press of (2,1)
    keys = 16'(1) << 9;
    base = n_pulse;
    wait_pulse(base, 64);
    chk("t2_code", 32'(key_code), 32'd9);
    chk("t2_held", 32'(key_held), 32'd1);
    step(60);
    chk("t2_once", 32'(n_pulse - base), 32'd1);
    keys = '0;
    step(80);
    chk("t2_release", 32'(key_held), 32'd0);

    // 3: (0,3) bouncing, then stable
    align_frame();
    base = n_pulse;
    repeat (3) begin
      keys = 16'(1) << 3; step(10);
      keys = '0;          step(10);
    end
    chk("t3_bounce", 32'(n_pulse - base), 32'd0);
    keys = 16'(1) << 3;
    step(60);
    chk("t3_once", 32'(n_pulse - base), 32'd1);
    chk("t3_code", 32'(key_code), 32'd3);
    keys = '0;
    step(80);

    // 4: two keys together, lower index wins; no rollover on partial release
    keys = (16'(1) << 4) | (16'(1) << 14);
    base = n_pulse;
    step(100);
    chk("t4_once", 32'(n_pulse - base), 32'd1);
    chk("t4_code", 32'(key_code), 32'd4);
    keys = 16'(1) << 14;
    base = n_pulse;
    step(100);
    chk("t4_nopulse", 32'(n_pulse - base), 32'd0);
    chk("t4_held", 32'(key_held), 32'd1);
    keys = '0;
    step(80);

    // 5: one-frame release gap is a bounce; three frames is a release
    keys = 16'(1) << 5;
    step(80);
    align_frame();
    base = n_pulse;
    keys = '0;
    step(FRAME);
    keys = 16'(1) << 5;
    step(64);
    chk("t5_nopulse", 32'(n_pulse - base), 32'd0);
    chk("t5_held", 32'(key_held), 32'd1);
    keys = '0;
    step(64);
    chk("t5_release", 32'(key_held), 32'd0);

    // 6: reset mid-hold discards state; held key re-debounces
    keys = 16'(1) << 15;
    step(80);
    chk("t6_held", 32'(key_held), 32'd1);
    chk("t6_code", 32'(key_code), 32'd15);
    base = n_pulse;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("t6_rst");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step(80);
    chk("t6_repulse", 32'(n_pulse - base), 32'd1);
    chk("t6_code2", 32'(key_code), 32'd15);
    keys = '0;
    step(80);

    // Random key sets, holds and bounces against the reference model
    for (int e = 0; e < 40; e++) begin
      case ($urandom_range(0, 3))
        0: keys = '0;
        1: keys = 16'(1) << $urandom_range(0, 15);
        2: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: begin
          k = $urandom_range(0, 15);
          repeat ($urandom_range(2, 6)) begin
            keys = keys ^ (16'(1) << k);
            step($urandom_range(1, 12));
          end
        end
      endcase
      step($urandom_range(4, 70));
    end
    keys = '0;
    step(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
